// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared memory-op, size and owner codes plus strobe/replication helpers.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALFWORD = 2'b01,
    SIZE_WORD     = 2'b10
  } mem_size_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LD   = 1'b1
  } owner_e;

  typedef struct packed {
    logic       rd;
    logic       err;
    owner_e     owner;
    logic [1:0] op;
    logic [1:0] size;
    logic [1:0] off;
  } resp_t;

  // size 2'b11 falls through to the word case everywhere below
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_HALFWORD ? off[0] : size[1] ? |off : 1'b0;
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE     ? 4'b0001 << off :
           size == SIZE_HALFWORD ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    return size == SIZE_BYTE     ? {4{wdata[7:0]}} :
           size == SIZE_HALFWORD ? {2{wdata[15:0]}} : wdata;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_load_align_ext.sv
// load_align_ext: selects the byte/halfword lane of a read word and sign- or zero-extends it.
//   dout   : raw BRAM read word
//   offset : byte offset addr[1:0] of the access
//   size   : access size code
//   op     : memory op code (selects sign vs zero extension)
//   data   : aligned, extended result (words pass through)
module load_align_ext
  import dmem_port_arbiter_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [1:0]  op,
  output logic [31:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;
  always_comb begin
    lane_b = dout[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? dout[31:16] : dout[15:0];
    sext   = op == MEM_READ_SEXT;
    data   = size == SIZE_BYTE     ? {{24{sext & lane_b[7]}}, lane_b} :
             size == SIZE_HALFWORD ? {{16{sext & lane_h[15]}}, lane_h} : dout;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares BRAM port B between the core load/store unit and the loader.
//   clk, reset                      : clock, asynchronous active-low reset
//   core_req/op/size/addr/wdata     : core request (op 00 means no request)
//   core_gnt/rvalid/rdata/err       : core grant, read response, misalignment flag
//   ld_req/we/addr/wdata            : loader word request
//   ld_gnt/rvalid/rdata             : loader grant and raw read response
//   enaB/weB/addrB/dinB/doutB       : BRAM port B (one-cycle read latency)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic [1:0]        core_op,
  input  logic [1:0]        core_size,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              enaB,
  output logic [3:0]        weB,
  output logic [ADDR_W-1:0] addrB,
  output logic [31:0]       dinB,
  input  logic [31:0]       doutB
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve;
  resp_t            resp;
  logic             core_act, core_mis, core_wr, ld_win, starved;
  logic [31:0]      aligned;
  logic             unused_bits;

  assign core_act = core_req && core_op != MEM_DISABLE;
  assign core_mis = misaligned(core_size, core_addr[1:0]);
  assign core_wr  = core_op == MEM_WRITE;
  assign starved  = starve == CNT_W'(STARVE_LIMIT);
  assign ld_win   = ld_req && (!core_act || starved);

  // grants are forced low while reset is asserted
  assign ld_gnt   = reset && ld_win;
  assign core_gnt = reset && core_act && !ld_win;

  // a misaligned core access is granted but never touches the BRAM
  assign enaB  = ld_gnt || (core_gnt && !core_mis);
  assign weB   = ld_gnt ? {4{ld_we}} :
                 (core_gnt && !core_mis && core_wr) ? byte_strobe(core_size, core_addr[1:0]) : 4'b0000;
  assign addrB = ld_win ? ld_addr[ADDR_W+1:2] : core_addr[ADDR_W+1:2];
  assign dinB  = ld_win ? ld_wdata : replicate(core_size, core_wdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
      resp   <= '0;
    end else begin
      starve     <= (!ld_req || ld_gnt) ? '0 : starved ? starve : starve + 1'b1;
      resp.rd    <= (ld_gnt && !ld_we) || (core_gnt && !core_wr);
      resp.err   <= core_gnt && core_mis;
      resp.owner <= ld_gnt ? OWN_LD : OWN_CORE;
      resp.op    <= core_op;
      resp.size  <= core_size;
      resp.off   <= core_addr[1:0];
    end
  end

  load_align_ext u_align (
    .dout  (doutB),
    .offset(resp.off),
    .size  (resp.size),
    .op    (resp.op),
    .data  (aligned)
  );

  assign core_rvalid = resp.rd && resp.owner == OWN_CORE;
  assign core_err    = resp.err;
  assign core_rdata  = (core_rvalid && !resp.err) ? aligned : '0;
  assign ld_rvalid   = resp.rd && resp.owner == OWN_LD;
  assign ld_rdata    = ld_rvalid ? doutB : '0;

  assign unused_bits = ^{core_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector table plus hand sequences for arbitration, bursts and reset.
module tb_dmem_port_arbiter;
  localparam logic [1:0] DIS = 2'b00, SX = 2'b01, ZX = 2'b10, WR = 2'b11;
  localparam logic [1:0] B = 2'b00, H = 2'b01, WD = 2'b10;

  logic        clk = 1'b0, reset = 1'b1;
  logic        core_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [1:0]  core_op = 2'b00, core_size = 2'b00;
  logic [31:0] core_addr = '0, core_wdata = '0, ld_addr = '0, ld_wdata = '0;
  logic        core_gnt, core_rvalid, core_err, ld_gnt, ld_rvalid, enaB;
  logic [31:0] core_rdata, ld_rdata, dinB;
  logic [3:0]  weB;
  logic [12:0] addrB;
  logic [31:0] doutB = '0;
  logic [31:0] mem [0:8191];
  int          n_cmp = 0, n_bad = 0;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_op(core_op), .core_size(core_size), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
  );

  always #5 clk = ~clk;

  // BRAM port B model: registered read of the old word, byte writes at the same edge
  always @(posedge clk) begin
    if (enaB) begin
      doutB <= mem[addrB];
      for (int i = 0; i < 4; i++) if (weB[i]) mem[addrB][8*i +: 8] <= dinB[8*i +: 8];
    end
  end

  typedef struct {
    logic creq; logic [1:0] cop; logic [1:0] csz; logic [31:0] caddr; logic [31:0] cwd;
    logic lreq; logic lwe; logic [31:0] laddr; logic [31:0] lwd;
    logic [1:0] gnt; logic en; logic [3:0] we; logic [12:0] addr; logic [31:0] din;
    logic [1:0] cresp; logic [31:0] crd; logic lrv; logic [31:0] lrd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    core_req = v.creq; core_op = v.cop; core_size = v.csz; core_addr = v.caddr; core_wdata = v.cwd;
    ld_req = v.lreq; ld_we = v.lwe; ld_addr = v.laddr; ld_wdata = v.lwd;
  endtask

  initial begin
    // creq op sz addr wdata | lreq lwe laddr lwdata | gnt{c,l} en we addrB dinB | {crv,cerr} crd lrv lrd
    add('{1'b0,DIS,B,32'h0,32'h0, 1'b1,1'b1,32'h0,32'h11223344, 2'b01,1'b1,4'hF,13'h000,32'h11223344, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b0,DIS,B,32'h0,32'h0, 1'b1,1'b1,32'h4,32'h80011234, 2'b01,1'b1,4'hF,13'h001,32'h80011234, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b0,DIS,B,32'h0,32'h0, 1'b1,1'b1,32'h10B,32'h0, 2'b01,1'b1,4'hF,13'h042,32'h0, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b1,WR,B,32'h102,32'hA5, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'b0100,13'h040,32'hA5A5A5A5, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b1,SX,B,32'h102,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h040,32'h0, 2'b10,32'hFFFFFFA5,1'b0,32'h0});
    add('{1'b1,ZX,B,32'h102,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h040,32'h0, 2'b10,32'h000000A5,1'b0,32'h0});
    add('{1'b1,SX,H,32'h6,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h001,32'h0, 2'b10,32'hFFFF8001,1'b0,32'h0});
    add('{1'b1,ZX,H,32'h4,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h001,32'h0, 2'b10,32'h00001234,1'b0,32'h0});
    add('{1'b1,SX,WD,32'h4,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h001,32'h0, 2'b10,32'h80011234,1'b0,32'h0});
    add('{1'b1,SX,WD,32'h2,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b0,4'h0,13'h000,32'h0, 2'b11,32'h0,1'b0,32'h0});
    add('{1'b1,WR,H,32'h10A,32'hBEEF, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'b1100,13'h042,32'hBEEFBEEF, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b1,ZX,WD,32'h108,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h042,32'h0, 2'b10,32'hBEEF0000,1'b0,32'h0});
    add('{1'b1,WR,H,32'h105,32'h1234, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b0,4'h0,13'h000,32'h0, 2'b01,32'h0,1'b0,32'h0});
    add('{1'b1,DIS,WD,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,1'b0,4'h0,13'h000,32'h0, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b0,SX,WD,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,1'b0,4'h0,13'h000,32'h0, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b0,DIS,B,32'h0,32'h0, 1'b1,1'b1,32'h2003,32'hDEADBEEF, 2'b01,1'b1,4'hF,13'h800,32'hDEADBEEF, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b0,DIS,B,32'h0,32'h0, 1'b1,1'b0,32'h2000,32'h0, 2'b01,1'b1,4'h0,13'h800,32'h0, 2'b00,32'h0,1'b1,32'hDEADBEEF});
    add('{1'b1,ZX,2'b11,32'hA000,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h800,32'h0, 2'b10,32'hDEADBEEF,1'b0,32'h0});
    add('{1'b1,WR,B,32'h10B,32'h7F, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'b1000,13'h042,32'h7F7F7F7F, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b1,SX,B,32'h10B,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h042,32'h0, 2'b10,32'h0000007F,1'b0,32'h0});
    add('{1'b1,SX,B,32'h10A,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h042,32'h0, 2'b10,32'hFFFFFFEF,1'b0,32'h0});
    add('{1'b1,SX,WD,32'h0,32'h0, 1'b1,1'b0,32'h4,32'h0, 2'b10,1'b1,4'h0,13'h000,32'h0, 2'b10,32'h11223344,1'b0,32'h0});
    add('{1'b1,WR,B,32'h1,32'hFFFFFF3C, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'b0010,13'h000,32'h3C3C3C3C, 2'b00,32'h0,1'b0,32'h0});
    add('{1'b1,ZX,WD,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b10,1'b1,4'h0,13'h000,32'h0, 2'b10,32'h11223C44,1'b0,32'h0});

    // reset held with both requesters active: everything must stay quiet
    #1 reset = 1'b0;
    core_req = 1'b1; core_op = SX; core_size = WD; ld_req = 1'b1; ld_we = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 0, {core_gnt, ld_gnt}, 2'b00);
    chk("rst_ena", 0, {enaB, weB}, 5'b0);
    chk("rst_resp", 0, {core_rvalid, core_err, ld_rvalid}, 3'b000);
    chk("rst_crd", 0, core_rdata, 32'h0);
    chk("rst_lrd", 0, ld_rdata, 32'h0);
    core_req = 1'b0; ld_req = 1'b0;
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("gnt", i, {core_gnt, ld_gnt}, tbl[i].gnt);
      chk("enaB", i, enaB, tbl[i].en);
      chk("weB", i, weB, tbl[i].we);
      if (tbl[i].en) chk("addrB", i, addrB, tbl[i].addr);
      if (tbl[i].we != 4'h0) chk("dinB", i, dinB, tbl[i].din);
      @(posedge clk);
      #1;
      chk("core_resp", i, {core_rvalid, core_err}, tbl[i].cresp);
      chk("core_rdata", i, core_rdata, tbl[i].crd);
      chk("ld_rvalid", i, ld_rvalid, tbl[i].lrv);
      chk("ld_rdata", i, ld_rdata, tbl[i].lrd);
    end

    // both requesting continuously: 8 core grants, then 1 loader grant, repeating
    @(negedge clk);
    core_req = 1'b1; core_op = ZX; core_size = WD; core_addr = 32'h0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h4;
    for (int c = 0; c < 27; c++) begin
      if (c > 0) begin
        chk("starve_lrv", c, ld_rvalid, ((c - 1) % 9) == 8);
        chk("starve_crv", c, core_rvalid, ((c - 1) % 9) != 8);
        chk("starve_lrd", c, ld_rdata, ((c - 1) % 9) == 8 ? 32'h80011234 : 32'h0);
        chk("starve_crd", c, core_rdata, ((c - 1) % 9) == 8 ? 32'h0 : 32'h11223C44);
      end
      #1;
      chk("starve_gnt", c, {core_gnt, ld_gnt}, (c % 9) == 8 ? 2'b01 : 2'b10);
      @(negedge clk);
    end

    // loader burst: 16 word writes then 16 reads, one grant per cycle
    core_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h4000 + 32'(4 * k); ld_wdata = 32'hC0DE0000 + 32'(k * 32'h111);
      #1;
      chk("burst_wgnt", k, {ld_gnt, enaB, weB}, 6'b11_1111);
      chk("burst_waddr", k, addrB, 13'h1000 + 13'(k));
      @(negedge clk);
    end
    for (int k = 0; k <= 16; k++) begin
      chk("burst_rvalid", k, ld_rvalid, k > 0);
      if (k > 0) chk("burst_rdata", k, ld_rdata, 32'hC0DE0000 + 32'((k - 1) * 32'h111));
      ld_req = k < 16; ld_we = 1'b0; ld_addr = 32'h4000 + 32'(4 * k);
      #1;
      chk("burst_rgnt", k, ld_gnt, k < 16);
      @(negedge clk);
    end

    // reset lands right after a read grant: the pending response is dropped
    ld_req = 1'b0;
    core_req = 1'b1; core_op = ZX; core_size = WD; core_addr = 32'h0;
    #1;
    chk("mid_gnt", 0, core_gnt, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rvalid", 0, {core_rvalid, core_err}, 2'b00);
    chk("mid_rdata", 0, core_rdata, 32'h0);
    chk("mid_quiet", 0, {core_gnt, enaB}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rvalid", 1, core_rvalid, 1'b0);
      chk("mid_gnt", 1, core_gnt, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_gnt", 0, {core_gnt, enaB}, 2'b11);
    @(negedge clk);
    core_req = 1'b0;
    chk("post_rvalid", 0, core_rvalid, 1'b1);
    chk("post_rdata", 0, core_rdata, 32'h11223C44);
    @(negedge clk);
    chk("post_single", 0, core_rvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequences and shares port B of the data-memory BRAM between two requesters: the core load/store unit and the program/debug loader. Turns each granted access into BRAM enable, byte-write strobes and a word address, and aligns and extends read data for the requester. The block sits between the execute/memory stage and the BRAM primitive, replacing direct drive of port B by the memory-stage input logic.

## Interface
- ADDR_W, 13, BRAM word-address width (8192 words)
- STARVE_LIMIT, 8, consecutive loader-wait cycles before the loader gets forced priority
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- core_req  input  1  core access request, held until core_gnt
- core_op  input  2  00 disable, 01 read sign-extend, 10 read zero-extend, 11 write
- core_size  input  2  00 byte, 01 halfword, 10 word (11 treated as word)
- core_addr  input  32  byte address
- core_wdata  input  32  write data, right-justified
- core_gnt  output  1  request accepted this cycle
- core_rvalid  output  1  read response valid
- core_rdata  output  32  extended/aligned read data
- core_err  output  1  misaligned-access flag, coincident with response cycle
- ld_req  input  1  loader request
- ld_we  input  1  1 = word write, 0 = word read
- ld_addr  input  32  byte address, word-aligned (addr[1:0] ignored)
- ld_wdata  input  32  write data
- ld_gnt  output  1  loader request accepted
- ld_rvalid  output  1  loader read response valid
- ld_rdata  output  32  raw read word
- enaB  output  1  BRAM port B enable
- weB  output  4  BRAM byte write enables
- addrB  output  ADDR_W  BRAM word address = addr[ADDR_W+1:2]
- dinB  output  32  BRAM write data
- doutB  input  32  BRAM read data, one-cycle latency

## Operation
- A request with core_op=00 is not a request; core_req is ignored in that case.
- Arbitration, evaluated combinationally each cycle: core wins by default; loader wins if core not requesting, or if starve count has reached STARVE_LIMIT.
- Starve counter: increments while ld_req is high and ld_gnt is low; clears on ld_gnt or when ld_req is low; saturates at STARVE_LIMIT.
- Granted write: enaB=1, weB from size/offset, dinB replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Byte strobes: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111. Loader writes always 1111.
- Granted read: enaB=1, weB=0000; response stage registers owner, op, size, addr[1:0].
- Read response: select the byte or halfword lane by the registered offset, then sign- or zero-extend by registered op. Word reads pass through.
- Misaligned core access (half with addr[0]=1; word with addr[1:0]!=0): granted, enaB=0, no memory change. Next cycle core_err=1, plus core_rvalid=1 with core_rdata=0 if it was a read.
- Out-of-range upper address bits are ignored (wrap modulo BRAM size).

## Timing
- gnt is combinational, same cycle as req; BRAM signals are driven in the same cycle.
- Read response: rvalid/rdata exactly one cycle after the grant, for one cycle. Back-to-back grants are allowed every cycle, with no bubbles.
- Writes produce no rvalid; the write completes at the grant clock edge.
- A read-after-write to the same address on consecutive cycles returns new data. BRAM port B is configured read-first-free, with the write taking effect at the edge.
- Reset low: starve counter 0, response stage cleared. core_rvalid, ld_rvalid and core_err are 0, and rdata outputs are 0. A response pending at reset assertion is dropped.
- Outputs enaB/weB/gnt are 0 while reset is low.

## Structure
- The shared package holds the memOp codes (MEM_DISABLE/READ_SEXT/READ_ZEXT/WRITE), the size codes (BYTE/HALFWORD/WORD) and the owner encoding (OWN_CORE/OWN_LD).
- Sub-module load_align_ext: combinational lane-select plus sign/zero extension. It takes doutB, offset, size and op, and is reused by any future second memory port.

## Test plan
- Core byte write 0xA5 to addr 0x102 -> weB=0100, dinB=0xA5A5A5A5, addrB=0x040. Then SEXT byte read of 0x102 -> next cycle core_rdata=0xFFFFFFA5; ZEXT read -> 0x000000A5.
- Core halfword read of addr 0x006, memory word 0x8001_1234 -> core_rdata=0xFFFF8001 one cycle after grant.
- Core and loader both request continuously -> core granted 8 cycles, loader granted on the 9th, pattern repeats; the loader is never starved beyond STARVE_LIMIT.
- Core word read of addr 0x0002 -> enaB=0, next cycle core_err=1, core_rvalid=1, core_rdata=0; memory is unchanged.
- Loader writes words 0..15 back-to-back, then reads them back-to-back -> one grant per cycle, ld_rvalid on every cycle after the first read, with data matching.
- Reset asserted in the cycle after a read grant -> no rvalid ever appears. After release, the first request is served normally.
